// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Width of one UART payload byte.
  localparam int UART_DATA_SIZE = 8;

  // Frame sequencer states: accept a byte, offer it, wait out the frame.
  typedef enum logic [1:0] {
    UART_ARB_IDLE  = 2'd0,
    UART_ARB_ISSUE = 2'd1,
    UART_ARB_DRAIN = 2'd2
  } type_uart_arb_states_e;

  // Round-robin successor of index k among n requesters.
  function automatic int wrap_inc(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping from N-1 back to 0. Returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW:0] pos;
  logic        found;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req_i[pos[PW-1:0]]) begin
        found                = 1'b1;
        gnt_o[pos[PW-1:0]]   = 1'b1;
        idx_o                = pos[PW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with
// message-granular round-robin, an owner lock released by a 'last' byte or
// by a stall timeout, and one-frame-at-a-time sequencing of the transmitter.
//
// Handshakes:
//   requester side: byte k is taken in the cycle where req_valid_i[k] and
//     req_ready_o[k] are both high; req_ready_o is a one-cycle one-hot pulse
//     asserted only in IDLE with tx_ready_i high.
//   transmitter side: tx_valid_o stays high in ISSUE until tx_ready_i is seen
//     low (frame started), then drops; the next byte is only offered after
//     tx_ready_i has returned high.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*UART_DATA_SIZE-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic [UART_DATA_SIZE-1:0]           tx_data_o,
  output logic                                tx_valid_o,
  input  logic                                tx_ready_i,
  output logic                                busy_o,
  output type_uart_arb_states_e               dbg_state_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit TO_EN = (LOCK_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  type_uart_arb_states_e          state_q, state_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic                           tx_valid_q, tx_valid_d;
  logic [UART_DATA_SIZE-1:0]      tx_data_q, tx_data_d;
  logic                           busy_q, busy_d;
  logic [PW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                           lock_q, lock_d;
  logic [PW-1:0]                  owner_q, owner_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0]             owner_oh;
  logic [NUM_REQ-1:0]             cand;
  logic [NUM_REQ-1:0]             arb_gnt;
  logic [PW-1:0]                  arb_idx;
  logic                           arb_any;
  logic                           accept;
  logic                           sel_last;
  logic                           owner_valid;
  logic                           timeout_hit;
  logic [UART_DATA_SIZE-1:0]      sel_data;

  // Decode the owner and mux out the byte of whichever requester wins.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    sel_data          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = req_data_i[i*UART_DATA_SIZE +: UART_DATA_SIZE];
    end
  end

  // While locked only the owner may compete; otherwise everyone does.
  assign cand        = req_valid_i & (lock_q ? owner_oh : {NUM_REQ{1'b1}});
  assign sel_last    = |(arb_gnt & req_last_i);
  assign owner_valid = |(owner_oh & req_valid_i);
  assign accept      = (state_q == UART_ARB_IDLE) && tx_ready_i && arb_any;
  assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST);

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Next-state logic for the frame sequencer, lock and timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    to_cnt_d   = to_cnt_q;
    unique case (state_q)
      UART_ARB_IDLE: begin
        if (accept) begin
          state_d    = UART_ARB_ISSUE;
          tx_valid_d = 1'b1;
          tx_data_d  = sel_data;
          grant_d    = arb_gnt;
          to_cnt_d   = '0;
          rr_ptr_d   = PW'(wrap_inc(int'(arb_idx), NUM_REQ));
          if (sel_last) begin
            lock_d = 1'b0;
          end else begin
            lock_d  = 1'b1;
            owner_d = arb_idx;
          end
        end else if (lock_q && !owner_valid) begin
          // A silent owner loses the grant once the counter reaches its limit.
          if (timeout_hit) begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = PW'(wrap_inc(int'(owner_q), NUM_REQ));
          end else if (TO_EN) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      UART_ARB_ISSUE: begin
        // Ready dropping means the transmitter has taken the byte.
        if (!tx_ready_i) begin
          state_d    = UART_ARB_DRAIN;
          tx_valid_d = 1'b0;
        end
      end
      UART_ARB_DRAIN: begin
        if (tx_ready_i) begin
          state_d = UART_ARB_IDLE;
          if (!lock_q) grant_d = '0;
        end
      end
      default: begin
        state_d    = UART_ARB_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != UART_ARB_IDLE) || lock_d;
  end

  // State and registered outputs; reset drops everything, including the held byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UART_ARB_IDLE;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      owner_q    <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign req_ready_o = accept ? arb_gnt : '0;
  assign grant_o     = grant_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NR      = 4;
  localparam int LT      = 16;
  localparam int TW      = 5;
  localparam int TX_BUSY = 40;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR*8-1:0]       req_data;
  logic [NR-1:0]         req_last;
  logic [NR-1:0]         req_ready_o;
  logic [NR-1:0]         grant_o;
  logic [7:0]            tx_data_o;
  logic                  tx_valid_o;
  logic                  tx_ready;
  logic                  tx_ready_m;
  logic                  stub_low;
  logic                  busy_o;
  type_uart_arb_states_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int dbl_cnt  = 0;
  int tx_cnt;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         acc_q[$];
  logic [7:0] pend_d[NR][$];
  logic       pend_l[NR][$];

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .LOCK_TIMEOUT (LT),
    .TO_W         (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Transmitter model: takes a byte when valid and ready, drops ready one
  // cycle later, stays busy for a frame, then goes ready again.
  assign tx_ready = tx_ready_m & ~stub_low;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt     <= 0;
      tx_ready_m <= 1'b1;
    end else begin
      if (tx_valid_o && tx_cnt >= 3) dbl_cnt <= dbl_cnt + 1;
      if (tx_cnt == 0) begin
        if (tx_valid_o && tx_ready) begin
          got_q.push_back(tx_data_o);
          tx_cnt <= 1;
        end
      end else if (tx_cnt == TX_BUSY) begin
        tx_ready_m <= 1'b1;
        tx_cnt     <= 0;
      end else begin
        if (tx_cnt == 1) tx_ready_m <= 1'b0;
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic load_valids();
    for (int k = 0; k < NR; k++) begin
      if (pend_d[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_data[k*8 +: 8] = pend_d[k][0];
        req_last[k]        = pend_l[k][0];
      end else begin
        req_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int k, input logic [7:0] d, input logic l);
    pend_d[k].push_back(d);
    pend_l[k].push_back(l);
  endtask

  // Present pending bytes and record which requester is accepted, until
  // max_acc accepts; then all valids drop.
  task automatic run(input string tag, input int max_acc);
    int n   = 0;
    int cyc = 0;
    int k;
    while (n < max_acc && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      load_valids();
      #1;
      if (req_ready_o != '0) begin
        check({tag, "_onehot"}, $countones(req_ready_o), 1);
        k = 0;
        for (int i = NR - 1; i >= 0; i--) if (req_ready_o[i]) k = i;
        acc_q.push_back(k);
        void'(pend_d[k].pop_front());
        void'(pend_l[k].pop_front());
        n++;
      end
    end
    @(negedge clk);
    req_valid = '0;
    check({tag, "_accepts"}, n, max_acc);
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (!(dbg_state == UART_ARB_IDLE && !busy_o) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic wait_state_idle(input string tag);
    int cyc = 0;
    while (dbg_state != UART_ARB_IDLE && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, dbg_state, UART_ARB_IDLE);
  endtask

  // Scoreboard: bytes seen by the transmitter against the expected queue.
  task automatic sb_check(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    stub_low  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", req_ready_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_state", dbg_state, UART_ARB_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // 1: single byte 0xA5 from req0
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[7:0] = 8'hA5; req_last[0] = 1'b1;
    #1;
    check("t1_ready", req_ready_o, 4'b0001);
    check("t1_grant_pre", grant_o, 0);
    check("t1_tx_valid_pre", tx_valid_o, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_tx_valid", tx_valid_o, 1);
    check("t1_tx_data", tx_data_o, 8'hA5);
    check("t1_grant", grant_o, 4'b0001);
    check("t1_busy", busy_o, 1);
    check("t1_ready_after", req_ready_o, 0);
    exp_q.push_back(8'hA5);
    wait_idle("t1");
    check("t1_grant_end", grant_o, 0);
    check("t1_tx_valid_end", tx_valid_o, 0);
    sb_check("t1");

    // 2: all four valid from a fresh reset, two rounds
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    for (int r = 1; r <= 2; r++) begin
      for (int k = 0; k < NR; k++) begin
        push_req(k, 8'(16 * r + k), 1'b1);
        exp_q.push_back(8'(16 * r + k));
      end
    end
    run("t2", 8);
    wait_idle("t2");
    check("t2_acc_n", acc_q.size(), 8);
    for (int i = 0; i < 8; i++) if (i < acc_q.size()) check("t2_order", acc_q[i], i % 4);
    sb_check("t2");

    // 3: req2 holds the lock across a two-byte message while req1 waits
    acc_q.delete();
    push_req(2, 8'h41, 1'b0);
    push_req(2, 8'h42, 1'b1);
    run("t3a", 1);
    wait_state_idle("t3_locked_idle");
    check("t3_lock_grant", grant_o, 4'b0100);
    check("t3_lock_busy", busy_o, 1);
    push_req(1, 8'h31, 1'b1);
    run("t3b", 2);
    wait_idle("t3");
    check("t3_acc_n", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("t3_order0", acc_q[0], 2);
      check("t3_order1", acc_q[1], 2);
      check("t3_order2", acc_q[2], 1);
    end
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h31);
    sb_check("t3");

    // 4a: req1 locks and goes silent; released after 16 idle cycles
    acc_q.delete();
    push_req(1, 8'h51, 1'b0);
    run("t4a", 1);
    req_valid[3] = 1'b1; req_data[31:24] = 8'h63; req_last[3] = 1'b1;
    wait_state_idle("t4_c0_state");
    #1;
    check("t4_c0_ready", req_ready_o, 0);
    check("t4_c0_grant", grant_o, 4'b0010);
    repeat (15) @(negedge clk);
    #1;
    check("t4_c15_grant", grant_o, 4'b0010);
    check("t4_c15_ready", req_ready_o, 0);
    @(negedge clk);
    #1;
    check("t4_c16_grant", grant_o, 0);
    check("t4_c16_ready", req_ready_o, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    exp_q.push_back(8'h51); exp_q.push_back(8'h63);
    wait_idle("t4a");
    sb_check("t4a");

    // 4b: owner returns in its last allowed cycle; accept wins, counter clears
    push_req(1, 8'h52, 1'b0);
    run("t4b", 1);
    req_valid[3] = 1'b1; req_data[31:24] = 8'h64; req_last[3] = 1'b1;
    wait_state_idle("t4_d0_state");
    repeat (15) @(negedge clk);
    req_valid[1] = 1'b1; req_data[15:8] = 8'h53; req_last[1] = 1'b0;
    #1;
    check("t4_owner_wins", req_ready_o, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_state_idle("t4_e0_state");
    #1;
    check("t4_e0_grant", grant_o, 4'b0010);
    repeat (15) @(negedge clk);
    #1;
    check("t4_cleared_grant", grant_o, 4'b0010);
    check("t4_cleared_ready", req_ready_o, 0);
    @(negedge clk);
    #1;
    check("t4_e16_ready", req_ready_o, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    exp_q.push_back(8'h52); exp_q.push_back(8'h53); exp_q.push_back(8'h64);
    wait_idle("t4b");
    sb_check("t4b");

    // 5: transmitter held not-ready blocks any accept
    @(negedge clk);
    stub_low = 1'b1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h77; req_last[0] = 1'b1;
    bad = 0;
    repeat (8) begin
      #1;
      if (req_ready_o != 0 || tx_valid_o) bad++;
      @(negedge clk);
    end
    check("t5_no_accept", bad, 0);
    check("t5_state", dbg_state, UART_ARB_IDLE);
    stub_low = 1'b0;
    #1;
    check("t5_release_ready", req_ready_o, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    exp_q.push_back(8'h77);
    wait_idle("t5");
    sb_check("t5");

    // 6: reset during ISSUE drops the held byte; next byte goes out once
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h99; req_last[0] = 1'b1;
    #1;
    check("t6_ready", req_ready_o, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t6_issue_valid", tx_valid_o, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx_valid", tx_valid_o, 0);
    check("t6_rst_grant", grant_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_tx_data", tx_data_o, 0);
    check("t6_rst_state", dbg_state, UART_ARB_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h5A; req_last[0] = 1'b1;
    #1;
    check("t6_ready2", req_ready_o, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    exp_q.push_back(8'h5A);
    wait_idle("t6");
    sb_check("t6");
    check("no_double_send", dbl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
